seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_char_decode.sv | 35 +++
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// character codes, active-low segment patterns ({g,f,e,d,c,b,a}) and
// the default decimal-point mask.
package seg_pkg;

    localparam logic [4:0] CH_DASH  = 5'd16;
    localparam logic [4:0] CH_BLANK = 5'd31;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] DEFAULT_DP_MASK = 8'b00010100;

    // Every code above the dash is rendered as a fully dark digit.
    function automatic logic isBlankCode(input logic [4:0] code);
        return code > CH_DASH;
    endfunction

endpackage

// File: rtl/seg_char_decode.sv
// Combinational character decoder: 5-bit character code to active-low
// seven-segment pattern. Digits, hex letters, a dash, and blank otherwise.
module seg_char_decode
    import seg_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    // Map each character code onto its segment pattern; unused codes go dark.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            5'd0:    o_seg = SEG_0;
            5'd1:    o_seg = SEG_1;
            5'd2:    o_seg = SEG_2;
            5'd3:    o_seg = SEG_3;
            5'd4:    o_seg = SEG_4;
            5'd5:    o_seg = SEG_5;
            5'd6:    o_seg = SEG_6;
            5'd7:    o_seg = SEG_7;
            5'd8:    o_seg = SEG_8;
            5'd9:    o_seg = SEG_9;
            5'd10:   o_seg = SEG_A;
            5'd11:   o_seg = SEG_B;
            5'd12:   o_seg = SEG_C;
            5'd13:   o_seg = SEG_D;
            5'd14:   o_seg = SEG_E;
            5'd15:   o_seg = SEG_F;
            CH_DASH: o_seg = SEG_DASH;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver. Each digit gets DIV
// clocks, the first of which is a dark guard cycle against ghosting. The
// display word is captured once per frame into a shadow register so a
// frame is never torn by upstream updates.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int             DIV     = 100000,
    parameter logic [7:0]     DP_MASK = DEFAULT_DP_MASK
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] display,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [1:0]    r_rstSync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [39:0]   r_shadow;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frameDone;

    logic          w_rstN;
    logic          w_slotEnd;
    logic          w_frameEnd;
    logic [4:0]    w_code;
    logic [6:0]    w_decSeg;
    logic          w_codeBlank;

    // Reset assertion is passed straight through; release is delayed two clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN     = r_rstSync[1];
    assign w_slotEnd  = (r_cnt == CNT_MAX);
    assign w_frameEnd = w_slotEnd && (r_idx == 3'd7);

    // Slot counter and digit index advance together at the end of each slot.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slotEnd) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Capture the display word once per frame, on the last cycle of digit 7.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_shadow <= {40{1'b1}};
        end else if (w_frameEnd) begin
            r_shadow <= display;
        end
    end

    // Select the character code of the digit currently being scanned.
    always_comb begin
        w_code = r_shadow[4:0];
        case (r_idx)
            3'd0: w_code = r_shadow[4:0];
            3'd1: w_code = r_shadow[9:5];
            3'd2: w_code = r_shadow[14:10];
            3'd3: w_code = r_shadow[19:15];
            3'd4: w_code = r_shadow[24:20];
            3'd5: w_code = r_shadow[29:25];
            3'd6: w_code = r_shadow[34:30];
            3'd7: w_code = r_shadow[39:35];
            default: w_code = r_shadow[4:0];
        endcase
    end

    seg_char_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_decSeg)
    );

    assign w_codeBlank = isBlankCode(w_code);

    // Register the pin drive: dark on guard cycles, otherwise the selected digit.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_an        <= 8'hFF;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_frameEnd;
            if (r_cnt == '0) begin
                r_an  <= 8'hFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(8'b1 << r_idx);
                r_seg <= w_decSeg;
                r_dp  <= w_codeBlank ? 1'b1 : ~DP_MASK[r_idx];
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frameDone;

endmodule
